// File: rtl/mips_cpu_bus_arbiter.sv
// mips_cpu_bus_arbiter
//   Shares one Avalon-MM memory port between an instruction-fetch master (i_*)
//   and a data master (d_*). Transfers follow the pattern IDLE -> GNT_x -> IDLE,
//   so there is always one idle cycle between transfers. While a grant is
//   active, the owner is wired combinationally through to the memory port.
//
//   Ports:
//     clk, reset        single clock; synchronous active-low reset
//     i_address/i_read  fetch master request; i_waitrequest/i_readdata go back to it
//     d_address/d_read/d_write/d_byteenable/d_writedata
//                       data master request; d_waitrequest/d_readdata go back to it
//     avm_*             shared memory port (avm_waitrequest/avm_readdata are inputs)
//     grant             one-hot owner status: bit0 fetch, bit1 data
//
//   Configuration:
//     MIPS_ARB_ROUND_ROBIN_EN  When defined, simultaneous requests alternate
//                              between the masters. When undefined, the data
//                              master has priority, and a starvation guard
//                              (STARVE_LIMIT) makes sure fetch eventually wins.
module mips_cpu_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_address,
  input  logic        i_read,
  output logic        i_waitrequest,
  output logic [31:0] i_readdata,
  input  logic [31:0] d_address,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [3:0]  d_byteenable,
  input  logic [31:0] d_writedata,
  output logic        d_waitrequest,
  output logic [31:0] d_readdata,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [3:0]  avm_byteenable,
  output logic [31:0] avm_writedata,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic [1:0]  grant
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_e;

  state_e state_q, state_d;
  logic   i_req, d_req;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

`ifdef MIPS_ARB_ROUND_ROBIN_EN
  // 0 = fetch was granted last, 1 = data was granted last
  logic rr_last_q, rr_last_d;
`else
  localparam int unsigned CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
`ifdef MIPS_ARB_ROUND_ROBIN_EN
      rr_last_q <= 1'b0;
`else
      starve_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
`ifdef MIPS_ARB_ROUND_ROBIN_EN
      rr_last_q <= rr_last_d;
`else
      starve_cnt_q <= starve_cnt_d;
`endif
    end
  end

  // Next-state logic and grant bookkeeping
  always_comb begin
    state_d = state_q;
`ifdef MIPS_ARB_ROUND_ROBIN_EN
    rr_last_d = rr_last_q;
`else
    starve_cnt_d = starve_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_req && d_req) begin
`ifdef MIPS_ARB_ROUND_ROBIN_EN
          state_d = rr_last_q ? GNT_I : GNT_D;
`else
          state_d = (starve_cnt_q == LIMIT) ? GNT_I : GNT_D;
`endif
        end else if (i_req) begin
          state_d = GNT_I;
        end else if (d_req) begin
          state_d = GNT_D;
        end
      end
      // Completion or an abandoned request both end the grant
      GNT_I: if (!i_req || !avm_waitrequest) state_d = IDLE;
      GNT_D: if (!d_req || !avm_waitrequest) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_q == IDLE && state_d == GNT_I) begin
`ifdef MIPS_ARB_ROUND_ROBIN_EN
      rr_last_d = 1'b0;
`else
      starve_cnt_d = '0;
`endif
    end else if (state_q == IDLE && state_d == GNT_D) begin
`ifdef MIPS_ARB_ROUND_ROBIN_EN
      rr_last_d = 1'b1;
`else
      // Count data grants that overtook a waiting fetch, saturating at the limit
      if (i_read && starve_cnt_q != LIMIT) starve_cnt_d = starve_cnt_q + CW'(1);
`endif
    end
  end

  // Memory port mux: the owner is passed straight through
  always_comb begin
    avm_address    = '0;
    avm_read       = 1'b0;
    avm_write      = 1'b0;
    avm_byteenable = '0;
    avm_writedata  = '0;
    grant          = 2'b00;
    i_waitrequest  = 1'b1;
    d_waitrequest  = 1'b1;
    case (state_q)
      GNT_I: begin
        avm_address    = i_address;
        avm_read       = i_read;
        avm_byteenable = '1;
        grant          = 2'b01;
        i_waitrequest  = avm_waitrequest;
      end
      GNT_D: begin
        avm_address    = d_address;
        // A simultaneous read+write request is treated as a write
        avm_read       = d_read & ~d_write;
        avm_write      = d_write;
        avm_byteenable = d_byteenable;
        avm_writedata  = d_writedata;
        grant          = 2'b10;
        d_waitrequest  = avm_waitrequest;
      end
      default: ;
    endcase
  end

  assign i_readdata = avm_readdata;
  assign d_readdata = avm_readdata;

endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
module tb_mips_cpu_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_address;
  logic        i_read;
  logic        i_waitrequest;
  logic [31:0] i_readdata;
  logic [31:0] d_address;
  logic        d_read;
  logic        d_write;
  logic [3:0]  d_byteenable;
  logic [31:0] d_writedata;
  logic        d_waitrequest;
  logic [31:0] d_readdata;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic [1:0]  grant;

  int vecs = 0;
  int errs = 0;

  mips_cpu_bus_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .i_address(i_address), .i_read(i_read),
    .i_waitrequest(i_waitrequest), .i_readdata(i_readdata),
    .d_address(d_address), .d_read(d_read), .d_write(d_write),
    .d_byteenable(d_byteenable), .d_writedata(d_writedata),
    .d_waitrequest(d_waitrequest), .d_readdata(d_readdata),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .grant(grant)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {grant, avm_read, avm_write, avm_byteenable, i_waitrequest, d_waitrequest}
  task automatic test_reset();
    logic [9:0] obs;
    reset = 1'b0;
    i_address = '0; i_read = 1'b0;
    d_address = '0; d_read = 1'b0; d_write = 1'b0;
    d_byteenable = '0; d_writedata = '0;
    avm_waitrequest = 1'b0; avm_readdata = '0;
    tick(); tick();
    obs = {grant, avm_read, avm_write, avm_byteenable, i_waitrequest, d_waitrequest};
    vecs++;
    if (obs !== 10'b00_0_0_0000_1_1) begin
      errs++; $display("FAIL reset_outputs: got %b expected %b", obs, 10'b00_0_0_0000_1_1);
    end
    reset = 1'b1;
    tick();
    obs = {grant, avm_read, avm_write, avm_byteenable, i_waitrequest, d_waitrequest};
    vecs++;
    if (obs !== 10'b00_0_0_0000_1_1) begin
      errs++; $display("FAIL idle_after_reset: got %b expected %b", obs, 10'b00_0_0_0000_1_1);
    end
  endtask

  task automatic test_fetch_only();
    logic [9:0] obs;
    i_address = 32'h0000_0010; i_read = 1'b1;
    avm_waitrequest = 1'b0; avm_readdata = 32'h1234_5678;
    tick();
    obs = {grant, avm_read, avm_write, avm_byteenable, i_waitrequest, d_waitrequest};
    vecs++;
    if (obs !== 10'b01_1_0_1111_0_1) begin
      errs++; $display("FAIL fetch_grant: got %b expected %b", obs, 10'b01_1_0_1111_0_1);
    end
    vecs++;
    if (avm_address !== 32'h0000_0010) begin
      errs++; $display("FAIL fetch_addr: got %h expected %h", avm_address, 32'h10);
    end
    vecs++;
    if ({i_readdata, d_readdata} !== {32'h1234_5678, 32'h1234_5678}) begin
      errs++; $display("FAIL readdata: got %h/%h expected 12345678", i_readdata, d_readdata);
    end
    tick();
    i_read = 1'b0;
    vecs++;
    if (grant !== 2'b00) begin
      errs++; $display("FAIL fetch_complete_idle: got %b expected 00", grant);
    end
  endtask

  task automatic test_write_wait();
    int wcnt = 0, dwcnt = 0, done = 0;
    d_address = 32'h0000_0200; d_write = 1'b1; d_byteenable = 4'b0011;
    d_writedata = 32'hDEAD_BEEF; avm_waitrequest = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (done != 0) d_write = 1'b0;
      if (avm_write) wcnt++;
      if (wcnt == 1 && avm_write) begin
        vecs++;
        if ({grant, avm_read, avm_byteenable, avm_writedata} !== {2'b10, 1'b0, 4'b0011, 32'hDEAD_BEEF}) begin
          errs++; $display("FAIL write_fields: got %b %b %b %h expected 10 0 0011 deadbeef",
                           grant, avm_read, avm_byteenable, avm_writedata);
        end
      end
      // Memory model: stall the first three cycles of the transfer
      avm_waitrequest = avm_write && (wcnt <= 3);
      #1;
      if (d_waitrequest && grant == 2'b10) dwcnt++;
      if (avm_write && !avm_waitrequest) done++;
    end
    vecs++;
    if (wcnt != 4) begin
      errs++; $display("FAIL write_hold_cycles: got %0d expected 4", wcnt);
    end
    vecs++;
    if (dwcnt != 3) begin
      errs++; $display("FAIL write_dwait_cycles: got %0d expected 3", dwcnt);
    end
    vecs++;
    if (done != 1) begin
      errs++; $display("FAIL write_completions: got %0d expected 1", done);
    end
    avm_waitrequest = 1'b0;
  endtask

  task automatic test_read_write_both();
    d_read = 1'b1; d_write = 1'b1; avm_waitrequest = 1'b0;
    tick();
    vecs++;
    if ({grant, avm_write, avm_read} !== 4'b10_1_0) begin
      errs++; $display("FAIL rw_both: got %b expected 1010", {grant, avm_write, avm_read});
    end
    tick();
    d_read = 1'b0; d_write = 1'b0;
  endtask

  task automatic test_owner_hold();
    i_address = 32'h0000_0100; i_read = 1'b1; avm_waitrequest = 1'b1;
    tick();
    d_write = 1'b1;
    tick(); tick();
    vecs++;
    if ({grant, d_waitrequest, avm_write} !== 4'b01_1_0) begin
      errs++; $display("FAIL owner_hold: got %b expected 0110", {grant, d_waitrequest, avm_write});
    end
    i_read = 1'b0;
    tick();
    vecs++;
    if (grant !== 2'b00) begin
      errs++; $display("FAIL abandon_idle: got %b expected 00", grant);
    end
    tick();
    vecs++;
    if (grant !== 2'b10) begin
      errs++; $display("FAIL data_after_abandon: got %b expected 10", grant);
    end
    avm_waitrequest = 1'b0;
    tick();
    d_write = 1'b0;
  endtask

  task automatic test_starvation();
    logic [1:0] exp_seq [10] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01,
                                 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
    int n = 0;
    reset = 1'b0; tick(); reset = 1'b1;
    i_address = 32'h0000_0100; d_address = 32'h0000_0200;
    i_read = 1'b1; d_read = 1'b1; avm_waitrequest = 1'b0;
    for (int c = 0; c < 40 && n < 10; c++) begin
      tick();
      if (grant != 2'b00) begin
        vecs++;
        if (grant !== exp_seq[n]) begin
          errs++; $display("FAIL starve_order[%0d]: got %b expected %b", n, grant, exp_seq[n]);
        end
        vecs++;
        if (avm_address !== ((exp_seq[n] == 2'b01) ? 32'h100 : 32'h200)) begin
          errs++; $display("FAIL starve_addr[%0d]: got %h", n, avm_address);
        end
        n++;
      end
    end
    vecs++;
    if (n != 10) begin
      errs++; $display("FAIL starve_timeout: got %0d grants expected 10", n);
    end
    tick();
    i_read = 1'b0; d_read = 1'b0;
  endtask

  task automatic test_reset_midtransfer();
    d_write = 1'b1; d_byteenable = 4'b1111; avm_waitrequest = 1'b1;
    tick();
    vecs++;
    if ({grant, avm_write} !== 3'b10_1) begin
      errs++; $display("FAIL mid_grant: got %b expected 101", {grant, avm_write});
    end
    tick();
    reset = 1'b0;
    tick();
    vecs++;
    if ({grant, avm_write, avm_read} !== 4'b00_0_0) begin
      errs++; $display("FAIL mid_abort: got %b expected 0000", {grant, avm_write, avm_read});
    end
    d_write = 1'b0; reset = 1'b1;
    i_address = 32'h0000_0040; i_read = 1'b1;
    tick();
    vecs++;
    if ({grant, avm_read} !== 3'b01_1) begin
      errs++; $display("FAIL post_reset_fetch: got %b expected 011", {grant, avm_read});
    end
    avm_waitrequest = 1'b0;
    tick();
    i_read = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_write_wait();
    test_read_write_both();
    test_owner_hold();
    test_starvation();
    test_reset_midtransfer();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/mips_cpu_bus_arbiter.md
MIPS_CPU_BUS_ARBITER -- requirements
Module: mips_cpu_bus_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, the maximum number of consecutive data grants while a fetch request is pending (fixed-priority mode only).
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-004 SHALL have port i_address  in  32  instruction-fetch master address.
REQ-005 SHALL have port i_read  in  1  fetch read request.
REQ-006 SHALL have port i_waitrequest  out  1  stall to fetch master.
REQ-007 SHALL have port i_readdata  out  32  read data to fetch master.
REQ-008 SHALL have port d_address  in  32  data master address.
REQ-009 SHALL have ports d_read and d_write  in  1 each  data master read and write requests.
REQ-010 SHALL have port d_byteenable  in  4  data master byte lanes.
REQ-011 SHALL have port d_writedata  in  32  data master write data.
REQ-012 SHALL have port d_waitrequest  out  1  stall to data master.
REQ-013 SHALL have port d_readdata  out  32  read data to data master.
REQ-014 SHALL have ports avm_address (out 32), avm_read (out 1), avm_write (out 1), avm_byteenable (out 4), avm_writedata (out 32): the shared Avalon memory port.
REQ-015 SHALL have ports avm_waitrequest (in 1) and avm_readdata (in 32): memory responses.
REQ-016 SHALL have port grant  out  2  one-hot owner status: bit0 fetch, bit1 data.

Function
REQ-017 SHALL use states IDLE, GNT_I and GNT_D.
REQ-018 IDLE: the master request is i_read for fetch and (d_read | d_write) for data; if no request, SHALL stay in IDLE.
REQ-019 IDLE with a single request SHALL move to that master's GNT state at the next edge.
REQ-020 IDLE with both requesting, without macro: SHALL grant data unless starve_cnt == STARVE_LIMIT, in which case fetch is granted.
REQ-021 starve_cnt SHALL increment, saturating at STARVE_LIMIT, on each data grant issued while i_read is high; it SHALL clear on any fetch grant.
REQ-022 In IDLE, avm_read and avm_write SHALL be 0, avm_byteenable 0, grant 2'b00, and both i_waitrequest and d_waitrequest 1.
REQ-023 In GNT_x, avm_address, avm_read, avm_write, avm_byteenable and avm_writedata SHALL be combinationally driven from the owning master.
REQ-024 For fetch, avm_write SHALL be 0 and avm_byteenable SHALL be 4'b1111.
REQ-025 If the data master asserts d_read and d_write together, the write SHALL be forwarded and avm_read forced to 0.
REQ-026 Owner waitrequest SHALL equal avm_waitrequest; the non-owner waitrequest SHALL be 1.
REQ-027 i_readdata and d_readdata SHALL both equal avm_readdata unconditionally.
REQ-028 Completion is a rising edge in GNT_x with avm_waitrequest == 0; SHALL return to IDLE on it, giving one idle bubble between transfers.
REQ-029 If the owner drops its request before completion, SHALL return to IDLE at the next edge with no completion signalled.
REQ-030 Owner SHALL NOT change while in GNT_x, regardless of the other master's requests.
REQ-031 Minimum transfer latency, from request sampled to completion edge, SHALL be 2 cycles for zero-wait memory.

Reset
REQ-032 When reset == 0 at a rising edge: state SHALL become IDLE, starve_cnt 0, rr_last SHALL select fetch, and outputs SHALL take the REQ-022 values.
REQ-033 Reset asserted mid-transfer SHALL abort it; avm_read and avm_write SHALL be 0 from the following cycle.

Configuration
REQ-034 With macro MIPS_ARB_ROUND_ROBIN_EN defined: when both request in IDLE, SHALL grant the master not recorded in register rr_last, and rr_last SHALL update on every grant; starve_cnt and STARVE_LIMIT are unused.
REQ-035 Without MIPS_ARB_ROUND_ROBIN_EN: fixed data priority with starvation guard per REQ-020 and REQ-021.

Verification
REQ-036 Only i_read=1 at 0x00000010, zero-wait memory -> grant=01 on cycle 1, avm_read=1 with avm_address=0x10 and avm_byteenable=4'b1111, i_waitrequest low that cycle, IDLE on cycle 2.
REQ-037 d_write=1, d_byteenable=4'b0011, d_writedata=0xDEADBEEF, avm_waitrequest high for 3 cycles -> d_waitrequest high for 3 cycles, avm_write held 4 cycles, single completion.
REQ-038 Both request continuously, no macro, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-039 Both request continuously, macro defined -> grant order D,I,D,I.
REQ-040 Reset driven low during a GNT_D wait state -> avm_write=0 and grant=00 the next cycle; after release an i_read is granted first if only fetch requests.
REQ-041 d_read and d_write asserted together -> avm_write=1 and avm_read=0.
